// File: rtl/la_mailbox_pkg.sv
// Shared encodings for the logic-analyzer mailbox controller:
// command ops, FSM states, status field positions and constants.
package la_mailbox_pkg;

    typedef logic [1:0] op_t;
    typedef logic [1:0] state_t;

    localparam op_t OP_NOP      = 2'b00;
    localparam op_t OP_READ     = 2'b01;
    localparam op_t OP_WRITE    = 2'b10;
    localparam op_t OP_CORE_RST = 2'b11;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_ISSUE     = 2'd1;
    localparam state_t ST_WAIT_RESP = 2'd2;
    localparam state_t ST_DONE      = 2'd3;

    localparam int CMD_W       = 65;
    localparam int CMD_TOG     = 64;
    localparam int CMD_OP_HI   = 63;
    localparam int CMD_OP_LO   = 62;
    localparam int CMD_ADDR_HI = 61;
    localparam int CMD_ADDR_LO = 32;
    localparam int CMD_DATA_HI = 31;

    localparam int STS_W        = 111;
    localparam int STS_RDATA_HI = 31;
    localparam int STS_ACK      = 32;
    localparam int STS_BUSY     = 33;
    localparam int STS_ERR      = 34;
    localparam int STS_CORE_RST = 35;
    localparam int STS_CNT_LO   = 36;
    localparam int STS_CNT_HI   = 43;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/la_toggle_sync.sv
// Two-flop synchronizer for the request toggle plus the accepted-toggle
// register; pending is high while a new, not yet accepted toggle is seen.
module la_toggle_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic toggle,
    input  logic accept,
    output logic pending
);

    logic meta;
    logic sync;
    logic accepted;

    // Synchronize the toggle and remember the last value taken as a command
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta     <= 1'b0;
            sync     <= 1'b0;
            accepted <= 1'b0;
        end else begin
            meta <= toggle;
            sync <= meta;
            if (accept) accepted <= sync;
        end
    end

    assign pending = sync ^ accepted;

endmodule

// File: rtl/la_mailbox_ctrl.sv
// Mailbox between the management SoC logic-analyzer pins and the SBC
// memory bus; also owns the RISC-V core reset line.
module la_mailbox_ctrl
    import la_mailbox_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic [CMD_W-1:0]     la_data_in,
    output logic [STS_W-1:0]     la_data_out,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [31:0]          mem_rdata_i,
    output logic                 core_rst_no
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    op_t         op;
    op_t         cmd_op;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic [7:0]  done_cnt;
    logic [7:0]  wait_cnt;
    logic        pending;
    logic        accept;

    assign cmd_op = la_data_in[CMD_OP_HI:CMD_OP_LO];
    assign accept = (state == ST_IDLE) && pending;

    la_toggle_sync u_sync (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .toggle  (la_data_in[CMD_TOG]),
        .accept  (accept),
        .pending (pending)
    );

    // Command FSM: capture, bus request, response wait with timeout, ack
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state       <= ST_IDLE;
            op          <= OP_NOP;
            rdata       <= '0;
            ack         <= 1'b0;
            err         <= 1'b0;
            done_cnt    <= '0;
            wait_cnt    <= '0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            core_rst_no <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op          <= cmd_op;
                        mem_we_o    <= (cmd_op == OP_WRITE);
                        mem_addr_o  <= {la_data_in[CMD_ADDR_HI:CMD_ADDR_LO], 2'b00};
                        mem_wdata_o <= la_data_in[CMD_DATA_HI:0];
                        if (cmd_op == OP_CORE_RST) core_rst_no <= ~la_data_in[0];
                        if (cmd_op == OP_READ || cmd_op == OP_WRITE)
                            state <= ST_ISSUE;
                        else
                            state <= ST_DONE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_gnt_i) begin
                        wait_cnt <= '0;
                        state    <= ST_WAIT_RESP;
                    end
                end
                ST_WAIT_RESP: begin
                    if (mem_rvalid_i) begin
                        if (op == OP_READ) rdata <= mem_rdata_i;
                        err   <= 1'b0;
                        state <= ST_DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err   <= 1'b1;
                        rdata <= TIMEOUT_RDATA;
                        state <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    ack      <= ~ack;
                    done_cnt <= done_cnt + 8'd1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req_o = (state == ST_ISSUE);

    // Pack the status word returned to the management SoC
    always_comb begin
        la_data_out                          = '0;
        la_data_out[STS_RDATA_HI:0]          = rdata;
        la_data_out[STS_ACK]                 = ack;
        la_data_out[STS_BUSY]                = (state != ST_IDLE);
        la_data_out[STS_ERR]                 = err;
        la_data_out[STS_CORE_RST]            = ~core_rst_no;
        la_data_out[STS_CNT_HI:STS_CNT_LO]   = done_cnt;
    end

endmodule

// File: tb/tb_la_mailbox_ctrl.sv
// Scoreboard bench for la_mailbox_ctrl: stimulus pushes the expected
// status at ack, a monitor pops and compares on every ack toggle.
module tb_la_mailbox_ctrl;
    import la_mailbox_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [64:0]  la_in = '0;
    logic [110:0] la_out;
    logic         mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata = '0;
    logic         core_rst_n;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        core;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    logic tog = 1'b0;
    logic prev_ack = 1'b0;

    always #5 clk = ~clk;

    la_mailbox_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .la_data_in   (la_in),
        .la_data_out  (la_out),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .core_rst_no  (core_rst_n)
    );

    task automatic check(input string name, input logic [110:0] act,
                         input logic [110:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] rd, input logic e,
                        input logic c, input logic [7:0] n);
        exp_t x;
        x.rdata = rd; x.err = e; x.core = c; x.cnt = n;
        sb.push_back(x);
    endtask

    task automatic send(input logic [1:0] op, input logic [29:0] addr,
                        input logic [31:0] data);
        tog = ~tog;
        la_in = {tog, op, addr, data};
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sb.size() != 0 || la_out[33]) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    task automatic serve(input int gw, input int rw, input bit give,
                         input logic [31:0] rd, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int reqc);
        int n = 0;
        reqc = 0;
        while (!mem_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", mem_req, 1);
        check("req_we", mem_we, we);
        check("req_addr", mem_addr, addr);
        if (we) check("req_wdata", mem_wdata, wd);
        while (mem_req && reqc < 20) begin
            mem_gnt = (reqc == gw);
            reqc++;
            @(negedge clk);
        end
        mem_gnt = 1'b0;
        if (give) begin
            for (int j = 1; j <= rw; j++) begin
                if (j == rw) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rd;
                end
                @(negedge clk);
                mem_rvalid = 1'b0;
            end
        end
    endtask

    // Monitor: every ack toggle must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_ack = la_out[32];
        end else if (la_out[32] !== prev_ack) begin
            prev_ack = la_out[32];
            if (sb.size() == 0) begin
                check("unexpected_ack", 1, 0);
            end else begin
                e = sb.pop_front();
                check("ack_rdata", la_out[31:0], e.rdata);
                check("ack_err", la_out[34], e.err);
                check("ack_core", la_out[35], e.core);
                check("ack_cnt", la_out[43:36], e.cnt);
                check("ack_busy", la_out[33], 0);
            end
        end
    end

    initial begin
        logic [110:0] rst_sts;
        logic         a0;
        int           n;
        int           reqc;

        rst_sts = '0;
        rst_sts[35] = 1'b1;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_status", la_out, rst_sts);
        check("rst_core", core_rst_n, 0);
        check("rst_req", mem_req, 0);

        push(32'h0, 1'b0, 1'b1, 8'd1);
        send(OP_CORE_RST, 30'h0, 32'h1);
        wait_idle("core_assert");
        check("core_held", core_rst_n, 0);
        push(32'h0, 1'b0, 1'b0, 8'd2);
        send(OP_CORE_RST, 30'h0, 32'h0);
        wait_idle("core_release");
        check("core_released", core_rst_n, 1);

        push(32'h0, 1'b0, 1'b0, 8'd3);
        a0 = la_out[32];
        send(OP_NOP, 30'h0, 32'h0);
        n = 0;
        while (la_out[32] === a0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("nop_latency", n, 4);
        wait_idle("nop");

        push(32'h0, 1'b0, 1'b0, 8'd4);
        send(OP_WRITE, 30'h100, 32'h1234_5678);
        serve(3, 2, 1'b1, 32'h5555_AAAA, 1'b1, 32'h400, 32'h1234_5678, reqc);
        check("write_req_cycles", reqc, 4);
        wait_idle("write");

        push(32'hCAFE_F00D, 1'b0, 1'b0, 8'd5);
        push(32'hCAFE_F00D, 1'b0, 1'b0, 8'd6);
        send(OP_READ, 30'h2, 32'h0);
        n = 0;
        while (!la_out[33] && n < 20) begin
            @(negedge clk);
            n++;
        end
        send(OP_NOP, 30'h0, 32'h0);
        serve(0, 1, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h8, 32'h0, reqc);
        wait_idle("read_then_nop");

        push(TIMEOUT_RDATA, 1'b1, 1'b0, 8'd7);
        a0 = la_out[32];
        send(OP_READ, 30'h3, 32'h0);
        serve(0, 0, 1'b0, 32'h0, 1'b0, 32'hC, 32'h0, reqc);
        n = 0;
        while (la_out[32] === a0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", n, 5);
        wait_idle("timeout");
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_1111;
        @(negedge clk);
        mem_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        check("late_rvalid_rdata", la_out[31:0], 32'hDEAD_BEEF);
        check("late_rvalid_err", la_out[34], 1);

        push(32'h600D_C0DE, 1'b0, 1'b0, 8'd8);
        send(OP_READ, 30'h4, 32'h0);
        serve(0, 4, 1'b1, 32'h600D_C0DE, 1'b0, 32'h10, 32'h0, reqc);
        wait_idle("rvalid_at_limit");

        for (int i = 0; i < 248; i++) begin
            push(32'h600D_C0DE, 1'b0, 1'b0, 8'(9 + i));
            send(OP_NOP, 30'h0, 32'h0);
            wait_idle("nop_wrap");
        end
        check("count_wrapped", la_out[43:36], 0);

        send(OP_READ, 30'h5, 32'h0);
        serve(0, 0, 1'b0, 32'h0, 1'b0, 32'h14, 32'h0, reqc);
        @(negedge clk);
        rst_n = 1'b0;
        la_in = '0;
        tog = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        @(negedge clk);
        mem_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_status", la_out, rst_sts);
        check("midrst_core", core_rst_n, 0);
        check("midrst_req", mem_req, 0);
        check("midrst_addr", mem_addr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
